// File: rtl/noc_serial_receiver_q.sv
// NoC local-port receiver: reassembles HEADER/DATA/TAIL flits into PACKET_BITS words
// and queues finished packets in a DEPTH-entry valid/ready FIFO with header-time slot reservation.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 16
`endif

module noc_serial_receiver_q #(
  parameter  int PACKET_BITS  = 16,
  parameter  int PADDING_BITS = 0,
  parameter  int DEPTH        = 2,
  localparam int FW           = `FLIT_DATA_WIDTH + 2,
  localparam int PW           = (PADDING_BITS > 0) ? PADDING_BITS : 1,
  localparam int CNTW         = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,          // synchronous, active-low
  input  logic                   i_flush,
  input  logic [FW-1:0]          i_down_flit,    // {type[1:0], data}
  input  logic                   i_down_enable,
  output logic                   o_down_ack,
  output logic                   o_down_rej,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [PW-1:0]          o_out_padding,
  output logic [PACKET_BITS-1:0] o_out_packet,
  output logic                   o_err_len,
  output logic [CNTW-1:0]        o_count
);

  localparam int W       = `FLIT_DATA_WIDTH;
  localparam int N_FLITS = (PACKET_BITS + W - 1) / W;
  localparam int STW     = N_FLITS * W;
  localparam int FCW     = $clog2(N_FLITS + 1);
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW      = PACKET_BITS + PW;

  localparam logic [1:0]      FT_HEADER = 2'd0;
  localparam logic [1:0]      FT_DATA   = 2'd1;
  localparam logic [1:0]      FT_TAIL   = 2'd2;
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(DEPTH);
  localparam logic [FCW-1:0]  N_C       = FCW'(N_FLITS);
  localparam logic [FCW-1:0]  N_M1_C    = FCW'(N_FLITS - 1);
  localparam logic [AW-1:0]   LAST_PTR  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECEIVING = 2'd1,
    S_DISCARD   = 2'd2
  } state_t;

  state_t                r_state;
  logic [FCW-1:0]        r_flit_cnt;
  logic [STW-1:0]        r_stage;
  logic [PW-1:0]         r_hdr_free;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNTW-1:0]       r_count;
  logic                  r_out_valid;
  logic [PACKET_BITS-1:0] r_out_packet;
  logic [PW-1:0]         r_out_padding;
  logic                  r_err_len;

  logic [1:0]      w_type;
  logic [W-1:0]    w_data;
  logic [PW-1:0]   w_hdr_field;
  logic            w_rej;
  state_t          w_state_next;
  logic [FCW-1:0]  w_cnt_next;
  logic [STW-1:0]  w_stage_next;
  logic [STW-1:0]  w_slot_data;
  logic [PW-1:0]   w_hdr_free_next;
  logic            w_push;
  logic            w_err;
  logic            w_pop;
  logic [CNTW-1:0] w_count_next;
  logic [AW-1:0]   w_rd_next;
  logic [AW-1:0]   w_wr_next;
  logic [EW-1:0]   w_push_entry;
  logic [EW-1:0]   w_head_next;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      ptr_inc = {AW{1'b0}};
    end else begin
      ptr_inc = ptr + AW'(1);
    end
  endfunction

  assign w_type       = i_down_flit[FW-1:W];
  assign w_data       = i_down_flit[W-1:0];
  assign w_hdr_field  = (PADDING_BITS > 0) ? w_data[PW-1:0] : {PW{1'b0}};
  assign w_push_entry = {r_hdr_free, w_slot_data[PACKET_BITS-1:0]};

  // A header is refused only in IDLE with every slot occupied; the check uses registered count.
  always_comb begin
    w_rej = 1'b0;
    if (i_down_enable && !i_flush && (r_state == S_IDLE) &&
        (w_type == FT_HEADER) && (r_count >= DEPTH_C)) begin
      w_rej = 1'b1;
    end else begin
      w_rej = 1'b0;
    end
  end

  assign o_down_rej = w_rej;
  assign o_down_ack = i_down_enable & ~w_rej;

  // Current staging word with the incoming payload dropped into slot r_flit_cnt.
  always_comb begin
    w_slot_data = r_stage;
    for (int s = 0; s < N_FLITS; s++) begin
      if (r_flit_cnt == FCW'(s)) begin
        w_slot_data[s*W +: W] = w_data;
      end else begin
        w_slot_data[s*W +: W] = r_stage[s*W +: W];
      end
    end
  end

  // Packet-assembly next state.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_flit_cnt;
    w_stage_next    = r_stage;
    w_hdr_free_next = r_hdr_free;
    w_push          = 1'b0;
    w_err           = 1'b0;
    if (i_down_enable) begin
      case (r_state)
        S_IDLE: begin
          if ((w_type == FT_HEADER) && !w_rej) begin
            w_state_next    = S_RECEIVING;
            w_cnt_next      = {FCW{1'b0}};
            w_stage_next    = {STW{1'b0}};
            w_hdr_free_next = w_hdr_field;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_RECEIVING: begin
          case (w_type)
            FT_DATA: begin
              if (r_flit_cnt < N_C) begin
                w_stage_next = w_slot_data;
                w_cnt_next   = r_flit_cnt + FCW'(1);
              end else begin
                w_err        = 1'b1;
                w_state_next = S_DISCARD;
              end
            end
            FT_TAIL: begin
              w_state_next = S_IDLE;
              if (r_flit_cnt == N_M1_C) begin
                w_stage_next = w_slot_data;
                w_push       = 1'b1;
              end else begin
                w_err = 1'b1;
              end
            end
            default: w_state_next = S_RECEIVING;
          endcase
        end
        S_DISCARD: begin
          if (w_type == FT_TAIL) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DISCARD;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // FIFO bookkeeping; the head after this edge is precomputed so out_* are plain registers.
  always_comb begin
    w_pop        = (r_count != {CNTW{1'b0}}) && i_out_ready;
    w_count_next = r_count + CNTW'(w_push) - CNTW'(w_pop);
    w_rd_next    = w_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_wr_next    = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    if (w_count_next == {CNTW{1'b0}}) begin
      w_head_next = {EW{1'b0}};
    end else if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_next = w_push_entry;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // State, staging and FIFO registers; reset beats flush beats normal operation.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_flit_cnt    <= {FCW{1'b0}};
      r_stage       <= {STW{1'b0}};
      r_hdr_free    <= {PW{1'b0}};
      r_wr_ptr      <= {AW{1'b0}};
      r_rd_ptr      <= {AW{1'b0}};
      r_count       <= {CNTW{1'b0}};
      r_out_valid   <= 1'b0;
      r_out_packet  <= {PACKET_BITS{1'b0}};
      r_out_padding <= {PW{1'b0}};
      r_err_len     <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        r_mem[e] <= {EW{1'b0}};
      end
    end else if (i_flush) begin
      r_state       <= S_IDLE;
      r_flit_cnt    <= {FCW{1'b0}};
      r_stage       <= {STW{1'b0}};
      r_hdr_free    <= {PW{1'b0}};
      r_wr_ptr      <= {AW{1'b0}};
      r_rd_ptr      <= {AW{1'b0}};
      r_count       <= {CNTW{1'b0}};
      r_out_valid   <= 1'b0;
      r_out_packet  <= {PACKET_BITS{1'b0}};
      r_out_padding <= {PW{1'b0}};
      r_err_len     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_flit_cnt    <= w_cnt_next;
      r_stage       <= w_stage_next;
      r_hdr_free    <= w_hdr_free_next;
      r_wr_ptr      <= w_wr_next;
      r_rd_ptr      <= w_rd_next;
      r_count       <= w_count_next;
      r_out_valid   <= (w_count_next != {CNTW{1'b0}});
      r_out_packet  <= w_head_next[PACKET_BITS-1:0];
      r_out_padding <= w_head_next[EW-1:PACKET_BITS];
      r_err_len     <= w_err;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
      end
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_packet  = r_out_packet;
  assign o_out_padding = r_out_padding;
  assign o_err_len     = r_err_len;
  assign o_count       = r_count;

endmodule

// File: tb/tb_noc_serial_receiver_q.sv
// Bench for noc_serial_receiver_q: directed scenarios plus randomized flit traffic
// checked against a packet-level queue model.
`define FLIT_DATA_WIDTH 16

module tb_noc_serial_receiver_q;

  localparam int PACKET_BITS = 32;
  localparam int PADDING_BITS = 4;
  localparam int DEPTH = 2;
  localparam int N_FLITS = 2;
  localparam logic [1:0] HDR = 2'd0;
  localparam logic [1:0] DAT = 2'd1;
  localparam logic [1:0] TL  = 2'd2;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_flush = 1'b0;
  logic [17:0] i_down_flit = 18'd0;
  logic        i_down_enable = 1'b0;
  logic        o_down_ack;
  logic        o_down_rej;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [3:0]  o_out_padding;
  logic [31:0] o_out_packet;
  logic        o_err_len;
  logic [1:0]  o_count;

  int n_checks = 0;
  int n_pass = 0;

  // packet-level reference model
  logic [35:0] m_q[$];
  logic [15:0] m_words[$];
  int          m_phase = 0;  // 0 waiting for header, 1 collecting, 2 discarding
  logic [3:0]  m_free = 4'd0;
  logic        m_err = 1'b0;
  logic        exp_ack, exp_rej, obs_ack, obs_rej;

  noc_serial_receiver_q #(
    .PACKET_BITS(PACKET_BITS), .PADDING_BITS(PADDING_BITS), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_down_flit(i_down_flit), .i_down_enable(i_down_enable),
    .o_down_ack(o_down_ack), .o_down_rej(o_down_rej),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_padding(o_out_padding), .o_out_packet(o_out_packet),
    .o_err_len(o_err_len), .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Drives one clock cycle, samples ack/rej mid-cycle, then advances the model past the edge.
  task automatic cycle(input logic en, input logic [1:0] ty, input logic [15:0] d,
                       input logic rdy, input logic fl, input logic rs);
    logic        pre_rej;
    logic [35:0] tmp;
    i_down_enable = en;
    i_down_flit   = {ty, d};
    i_out_ready   = rdy;
    i_flush       = fl;
    i_rst         = rs;
    #2;
    pre_rej = en && !fl && (m_phase == 0) && (ty == HDR) && (m_q.size() >= DEPTH);
    exp_rej = pre_rej;
    exp_ack = en && !pre_rej;
    obs_ack = o_down_ack;
    obs_rej = o_down_rej;
    @(posedge clk);
    m_err = 1'b0;
    if (!rs || fl) begin
      m_q.delete();
      m_words.delete();
      m_phase = 0;
    end else begin
      if (m_q.size() > 0 && rdy) tmp = m_q.pop_front();
      if (en) begin
        if (m_phase == 0) begin
          if (ty == HDR && !pre_rej) begin
            m_phase = 1;
            m_words.delete();
            m_free = d[3:0];
          end
        end else if (m_phase == 1) begin
          if (ty == DAT) begin
            if (m_words.size() < N_FLITS) m_words.push_back(d);
            else begin
              m_err = 1'b1;
              m_phase = 2;
            end
          end else if (ty == TL) begin
            m_words.push_back(d);
            if (m_words.size() == N_FLITS) m_q.push_back({m_free, m_words[1], m_words[0]});
            else m_err = 1'b1;
            m_phase = 0;
          end
        end else if (ty == TL) begin
          m_phase = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, HDR, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, HDR, 16'h0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_out_valid); else n_pass++;
    n_checks++; if (o_out_packet !== 32'h0) $display("FAIL reset_packet got %h want 0", o_out_packet); else n_pass++;
    n_checks++; if (o_out_padding !== 4'h0) $display("FAIL reset_padding got %h want 0", o_out_padding); else n_pass++;
    n_checks++; if (o_count !== 2'd0) $display("FAIL reset_count got %0d want 0", o_count); else n_pass++;
    n_checks++; if (o_err_len !== 1'b0) $display("FAIL reset_err got %b want 0", o_err_len); else n_pass++;
    cycle(1'b0, HDR, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    cycle(1'b1, HDR, 16'h000A, 1'b1, 1'b0, 1'b1);
    n_checks++; if (obs_ack !== 1'b1) $display("FAIL basic_hdr_ack got %b want 1", obs_ack); else n_pass++;
    cycle(1'b1, DAT, 16'h5678, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'h1234, 1'b1, 1'b0, 1'b1);
    n_checks++; if (o_out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", o_out_valid); else n_pass++;
    n_checks++; if (o_out_packet !== 32'h1234_5678) $display("FAIL basic_packet got %h want 12345678", o_out_packet); else n_pass++;
    n_checks++; if (o_out_padding !== 4'hA) $display("FAIL basic_padding got %h want a", o_out_padding); else n_pass++;
    cycle(1'b0, HDR, 16'h0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (o_count !== 2'd0) $display("FAIL basic_popped_count got %0d want 0", o_count); else n_pass++;
    n_checks++; if (o_out_packet !== 32'h0) $display("FAIL basic_popped_packet got %h want 0", o_out_packet); else n_pass++;
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, HDR, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h1111, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'h2222, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, HDR, 16'h0002, 1'b0, 1'b0, 1'b1);
    n_checks++; if (obs_ack !== 1'b1) $display("FAIL b2b_hdr2_ack got %b want 1", obs_ack); else n_pass++;
    cycle(1'b1, DAT, 16'h3333, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'h4444, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_count !== 2'd2) $display("FAIL b2b_full_count got %0d want 2", o_count); else n_pass++;
    n_checks++; if (o_out_packet !== 32'h2222_1111) $display("FAIL b2b_head_a got %h want 22221111", o_out_packet); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, HDR, 16'h0003, 1'b0, 1'b0, 1'b1);
      n_checks++; if (obs_rej !== 1'b1 || obs_ack !== 1'b0) $display("FAIL b2b_rej cycle %0d got rej=%b ack=%b want rej=1 ack=0", k, obs_rej, obs_ack); else n_pass++;
    end
    cycle(1'b1, HDR, 16'h0003, 1'b1, 1'b0, 1'b1);
    n_checks++; if (obs_rej !== 1'b1) $display("FAIL b2b_rej_on_pop got %b want 1", obs_rej); else n_pass++;
    cycle(1'b1, HDR, 16'h0003, 1'b0, 1'b0, 1'b1);
    n_checks++; if (obs_ack !== 1'b1 || obs_rej !== 1'b0) $display("FAIL b2b_hdr3_ack got ack=%b rej=%b want ack=1 rej=0", obs_ack, obs_rej); else n_pass++;
    cycle(1'b1, DAT, 16'h5555, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'h6666, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_out_packet !== 32'h4444_3333 || o_out_padding !== 4'h2) $display("FAIL b2b_head_b got %h/%h want 44443333/2", o_out_packet, o_out_padding); else n_pass++;
    cycle(1'b0, HDR, 16'h0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (o_out_packet !== 32'h6666_5555 || o_out_padding !== 4'h3) $display("FAIL b2b_head_c got %h/%h want 66665555/3", o_out_packet, o_out_padding); else n_pass++;
    cycle(1'b0, HDR, 16'h0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (o_count !== 2'd0) $display("FAIL b2b_drained got %0d want 0", o_count); else n_pass++;
  endtask

  task automatic test_short();
    cycle(1'b1, HDR, 16'h0005, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'hBEEF, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_err_len !== 1'b1) $display("FAIL short_err got %b want 1", o_err_len); else n_pass++;
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL short_valid got %b want 0", o_out_valid); else n_pass++;
    cycle(1'b0, HDR, 16'h0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_err_len !== 1'b0) $display("FAIL short_err_pulse got %b want 0", o_err_len); else n_pass++;
    cycle(1'b1, HDR, 16'h0006, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'h0002, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_out_packet !== 32'h0002_0001 || o_out_padding !== 4'h6) $display("FAIL short_next got %h/%h want 00020001/6", o_out_packet, o_out_padding); else n_pass++;
    cycle(1'b0, HDR, 16'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_long();
    cycle(1'b1, HDR, 16'h0007, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h0002, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_err_len !== 1'b0) $display("FAIL long_err_early got %b want 0", o_err_len); else n_pass++;
    cycle(1'b1, DAT, 16'h0003, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_err_len !== 1'b1 || obs_ack !== 1'b1) $display("FAIL long_err got err=%b ack=%b want 1/1", o_err_len, obs_ack); else n_pass++;
    cycle(1'b1, TL, 16'h0004, 1'b0, 1'b0, 1'b1);
    n_checks++; if (obs_ack !== 1'b1 || o_err_len !== 1'b0) $display("FAIL long_tail got ack=%b err=%b want 1/0", obs_ack, o_err_len); else n_pass++;
    n_checks++; if (o_count !== 2'd0 || o_out_valid !== 1'b0) $display("FAIL long_nopush got count=%0d valid=%b want 0/0", o_count, o_out_valid); else n_pass++;
  endtask

  task automatic test_push_pop();
    cycle(1'b1, HDR, 16'h0007, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'hBBBB, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, HDR, 16'h0008, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'hCCCC, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'hDDDD, 1'b1, 1'b0, 1'b1);
    n_checks++; if (o_count !== 2'd1) $display("FAIL pp_count got %0d want 1", o_count); else n_pass++;
    n_checks++; if (o_out_packet !== 32'hDDDD_CCCC || o_out_padding !== 4'h8) $display("FAIL pp_head got %h/%h want ddddcccc/8", o_out_packet, o_out_padding); else n_pass++;
    cycle(1'b0, HDR, 16'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_flush_reset();
    cycle(1'b1, HDR, 16'h0009, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h1357, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'h2468, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, HDR, 16'h0009, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h1357, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'h2468, 1'b0, 1'b1, 1'b1);
    n_checks++; if (obs_ack !== 1'b1) $display("FAIL flush_ack got %b want 1", obs_ack); else n_pass++;
    n_checks++; if (o_count !== 2'd0 || o_out_valid !== 1'b0 || o_err_len !== 1'b0) $display("FAIL flush_clear got count=%0d valid=%b err=%b want 0/0/0", o_count, o_out_valid, o_err_len); else n_pass++;
    cycle(1'b1, TL, 16'h2468, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_count !== 2'd0 || o_err_len !== 1'b0) $display("FAIL flush_stray got count=%0d err=%b want 0/0", o_count, o_err_len); else n_pass++;
    cycle(1'b1, HDR, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h0101, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h0202, 1'b0, 1'b0, 1'b0);
    n_checks++; if (o_count !== 2'd0 || o_out_valid !== 1'b0 || o_out_packet !== 32'h0 || o_err_len !== 1'b0) $display("FAIL midrst got count=%0d valid=%b pkt=%h err=%b want zeros", o_count, o_out_valid, o_out_packet, o_err_len); else n_pass++;
    cycle(1'b1, HDR, 16'h000C, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, DAT, 16'h0F0F, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, TL,  16'hF0F0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (o_out_packet !== 32'hF0F0_0F0F || o_out_padding !== 4'hC) $display("FAIL after_rst got %h/%h want f0f00f0f/c", o_out_packet, o_out_padding); else n_pass++;
    cycle(1'b0, HDR, 16'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic        en, rdy, fl;
    logic [1:0]  ty;
    logic [35:0] e_head;
    int          r;
    for (int c = 0; c < 1500; c++) begin
      en  = ($urandom % 4) != 0;
      r   = $urandom % 10;
      ty  = (r < 3) ? HDR : ((r < 7) ? DAT : TL);
      rdy = ($urandom % 3) != 0;
      fl  = ($urandom % 100) == 0;
      cycle(en, ty, 16'($urandom), rdy, fl, 1'b1);
      e_head = (m_q.size() > 0) ? m_q[0] : 36'h0;
      n_checks++; if (obs_ack !== exp_ack) $display("FAIL rnd_ack c%0d got %b want %b", c, obs_ack, exp_ack); else n_pass++;
      n_checks++; if (obs_rej !== exp_rej) $display("FAIL rnd_rej c%0d got %b want %b", c, obs_rej, exp_rej); else n_pass++;
      n_checks++; if (o_out_valid !== (m_q.size() > 0)) $display("FAIL rnd_valid c%0d got %b want %b", c, o_out_valid, m_q.size() > 0); else n_pass++;
      n_checks++; if (o_out_packet !== e_head[31:0]) $display("FAIL rnd_packet c%0d got %h want %h", c, o_out_packet, e_head[31:0]); else n_pass++;
      n_checks++; if (o_out_padding !== e_head[35:32]) $display("FAIL rnd_padding c%0d got %h want %h", c, o_out_padding, e_head[35:32]); else n_pass++;
      n_checks++; if (o_count !== 2'(m_q.size())) $display("FAIL rnd_count c%0d got %0d want %0d", c, o_count, m_q.size()); else n_pass++;
      n_checks++; if (o_err_len !== m_err) $display("FAIL rnd_err c%0d got %b want %b", c, o_err_len, m_err); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short();
    test_long();
    test_push_pop();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
